// File: rtl/microcode_store.sv
// microcode_store: writable control store streamed in byte-serially at boot, then read with 1-cycle latency.
// Optional feature: define MICROCODE_CHECKSUM_EN to require a trailing 8-bit sum byte after the last word.
module microcode_store #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              N_RST,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [WORD_W-1:0] OUT,
  input  logic              BOOT_START,
  input  logic [7:0]        BOOT_DATA,
  input  logic              BOOT_VALID,
  output logic              BOOT_READY,
  output logic              BOOTED,
  output logic              BOOT_ERR
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LANES  = WORD_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

`ifdef MICROCODE_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    ERR   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;
`endif

  state_t              state_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [LANE_W-1:0]   lane_r;
  logic [WORD_W-1:0]   partial_r;
  logic [WORD_W-1:0]   out_r;
  logic                ready_r;
  logic                booted_r;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   word_s;
  logic                accept_s;
  logic                wr_en_s;

`ifdef MICROCODE_CHECKSUM_EN
  logic [7:0] sum_r;
  logic       err_r;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign BOOT_ERR = err_r;
`else
  assign BOOT_ERR = 1'b0;
`endif

  assign OUT        = out_r;
  assign BOOT_READY = ready_r;
  assign BOOTED     = booted_r;
  assign accept_s   = BOOT_VALID && ready_r;
  // Reset and restart both win over a same-cycle final byte, so the word is never committed
  assign wr_en_s    = N_RST && !BOOT_START && (state_r == LOAD) && accept_s && (lane_r == LAST_LANE);

  // Merge the incoming byte into its little-endian lane of the word being assembled
  always_comb begin
    word_s = partial_r;
    word_s[lane_r*8 +: 8] = BOOT_DATA;
  end

  // Control store array, deliberately without reset so it maps onto RAM
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem[waddr_r] <= word_s;
    end
  end

  // Load/run state machine with all handshake and read outputs registered
  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state_r   <= IDLE;
      waddr_r   <= {ADDR_W{1'b0}};
      lane_r    <= {LANE_W{1'b0}};
      partial_r <= {WORD_W{1'b0}};
      out_r     <= {WORD_W{1'b0}};
      ready_r   <= 1'b0;
      booted_r  <= 1'b0;
`ifdef MICROCODE_CHECKSUM_EN
      sum_r     <= 8'h00;
      err_r     <= 1'b0;
`endif
    end else if (BOOT_START) begin
      state_r   <= LOAD;
      waddr_r   <= {ADDR_W{1'b0}};
      lane_r    <= {LANE_W{1'b0}};
      partial_r <= {WORD_W{1'b0}};
      out_r     <= {WORD_W{1'b0}};
      ready_r   <= 1'b1;
      booted_r  <= 1'b0;
`ifdef MICROCODE_CHECKSUM_EN
      sum_r     <= 8'h00;
      err_r     <= 1'b0;
`endif
    end else begin
      out_r <= {WORD_W{1'b0}};
      case (state_r)
        LOAD: begin
          if (accept_s) begin
`ifdef MICROCODE_CHECKSUM_EN
            sum_r <= csum_add(sum_r, BOOT_DATA);
`endif
            if (lane_r == LAST_LANE) begin
              lane_r    <= {LANE_W{1'b0}};
              partial_r <= {WORD_W{1'b0}};
              waddr_r   <= waddr_r + ADDR_W'(1);
              if (waddr_r == LAST_ADDR) begin
`ifdef MICROCODE_CHECKSUM_EN
                state_r  <= CHECK;
`else
                state_r  <= RUN;
                ready_r  <= 1'b0;
                booted_r <= 1'b1;
`endif
              end
            end else begin
              lane_r    <= lane_r + LANE_W'(1);
              partial_r <= word_s;
            end
          end
        end
        RUN: begin
          out_r <= mem[ADDR];
        end
`ifdef MICROCODE_CHECKSUM_EN
        CHECK: begin
          if (accept_s) begin
            ready_r <= 1'b0;
            if (BOOT_DATA == sum_r) begin
              state_r  <= RUN;
              booted_r <= 1'b1;
            end else begin
              state_r  <= ERR;
              err_r    <= 1'b1;
            end
          end
        end
`endif
        default: begin
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_store.sv
// Directed bench for microcode_store (ADDR_W=2, WORD_W=16): expectations go into a scoreboard queue,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_microcode_store;
  localparam int ADDR_W = 2;
  localparam int WORD_W = 16;

  logic              CLK = 1'b0;
  logic              N_RST;
  logic [ADDR_W-1:0] ADDR;
  logic [WORD_W-1:0] OUT;
  logic              BOOT_START;
  logic [7:0]        BOOT_DATA;
  logic              BOOT_VALID;
  logic              BOOT_READY;
  logic              BOOTED;
  logic              BOOT_ERR;

  typedef struct {
    string             name;
    logic [WORD_W-1:0] out;
    logic              rdy;
    logic              booted;
    logic              err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic chk_req = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  microcode_store #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .CLK        (CLK),
    .N_RST      (N_RST),
    .ADDR       (ADDR),
    .OUT        (OUT),
    .BOOT_START (BOOT_START),
    .BOOT_DATA  (BOOT_DATA),
    .BOOT_VALID (BOOT_VALID),
    .BOOT_READY (BOOT_READY),
    .BOOTED     (BOOTED),
    .BOOT_ERR   (BOOT_ERR)
  );

  // Monitor: compares DUT outputs with the oldest queued expectation
  always @(negedge CLK) begin
    if (chk_req) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got a sample request, required a queued expectation");
      end else begin
        cur = sb.pop_front();
        if ({OUT, BOOT_READY, BOOTED, BOOT_ERR} !== {cur.out, cur.rdy, cur.booted, cur.err}) begin
          n_fail++;
          $display("FAIL %s: got out=%h rdy=%b booted=%b err=%b, required out=%h rdy=%b booted=%b err=%b",
                   cur.name, OUT, BOOT_READY, BOOTED, BOOT_ERR, cur.out, cur.rdy, cur.booted, cur.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic v, input logic [7:0] d);
    BOOT_VALID = v;
    BOOT_DATA  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_st(input string nm, input logic [WORD_W-1:0] o,
                           input logic r, input logic b, input logic e);
    exp_t x;
    x.name = nm; x.out = o; x.rdy = r; x.booted = b; x.err = e;
    sb.push_back(x);
    chk_req = 1'b1;
    @(negedge CLK);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic start_load();
    BOOT_START = 1'b1;
    step(1'b0, 8'h00);
    BOOT_START = 1'b0;
    expect_st("start", 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  // Eight bytes base..base+7, optionally with an idle (invalid, garbage) cycle between them
  task automatic feed(input logic [7:0] base, input bit gap);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (gap && i != 0) step(1'b0, 8'hEE);
      step(1'b1, base + 8'(i));
      s = s + base + 8'(i);
      if (i == 6) expect_st("pre_last", 16'h0000, 1'b1, 1'b0, 1'b0);
    end
    BOOT_VALID = 1'b0;
`ifdef MICROCODE_CHECKSUM_EN
    expect_st("check_wait", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, s);
    BOOT_VALID = 1'b0;
`endif
    expect_st("booted", 16'h0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic read_all(input logic [7:0] base);
    logic [7:0] lo;
    for (int i = 0; i < 4; i++) begin
      ADDR = ADDR_W'(i);
      lo = base + 8'(2 * i);
      step(1'b0, 8'h00);
      expect_st("read", {lo + 8'h01, lo}, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    N_RST = 1'b0; BOOT_START = 1'b0; BOOT_VALID = 1'b1; BOOT_DATA = 8'hFF; ADDR = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    expect_st("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    N_RST = 1'b1;
    step(1'b1, 8'h77);
    expect_st("idle_ignores", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Basic load and read-back
    start_load();
    feed(8'h01, 1'b0);
    read_all(8'h01);
    step(1'b1, 8'h99);
    step(1'b1, 8'h98);
    read_all(8'h01);

    // Restart after three bytes; the same-cycle byte AA must be dropped
    start_load();
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    BOOT_START = 1'b1;
    step(1'b1, 8'hAA);
    BOOT_START = 1'b0;
    BOOT_VALID = 1'b0;
    expect_st("restart", 16'h0000, 1'b1, 1'b0, 1'b0);
    feed(8'h11, 1'b0);
    read_all(8'h11);

    // Backpressure: valid toggles, idle cycles carry garbage
    start_load();
    feed(8'h01, 1'b1);
    read_all(8'h01);

    // Reset in the middle of a load, with a byte completing a word at the reset edge
    start_load();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h41 + 8'(i));
    N_RST = 1'b0;
    step(1'b1, 8'h46);
    N_RST = 1'b1;
    BOOT_VALID = 1'b0;
    expect_st("mid_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h47);
    expect_st("after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    start_load();
    feed(8'h51, 1'b0);
    read_all(8'h51);

`ifdef MICROCODE_CHECKSUM_EN
    // Wrong checksum byte: 25 instead of 24
    start_load();
    for (int i = 0; i < 8; i++) step(1'b1, 8'h01 + 8'(i));
    BOOT_VALID = 1'b0;
    expect_st("csum_wait", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h25);
    BOOT_VALID = 1'b0;
    expect_st("csum_err", 16'h0000, 1'b0, 1'b0, 1'b1);
    ADDR = 2'd2;
    step(1'b0, 8'h00);
    expect_st("err_hold", 16'h0000, 1'b0, 1'b0, 1'b1);
    start_load();
    feed(8'h01, 1'b0);
    read_all(8'h01);
`endif

    step(1'b0, 8'h00);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover expectations, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
